// File: rtl/bypass_fifo_path.sv
// Single-clock FIFO with an optional zero-latency bypass when empty.
// Push/pop strobes, pointers and error pulses are exported for checking.
module bypass_fifo_path #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SLACK     = 0,
    parameter bit          BYPASS_EN = 1'b1,
    localparam int unsigned PWIDTH   = $clog2(DEPTH),
    localparam int unsigned CWIDTH   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic              stall_o,
    output logic              req_o,
    input  logic              gnt_i,
    output logic [DWIDTH-1:0] data_o,
    input  logic              flush_i,
    output logic              write_i,
    output logic              read_i,
    output logic              empty,
    output logic              full,
    output logic [PWIDTH-1:0] rd_ptr,
    output logic [PWIDTH-1:0] wr_ptr,
    output logic [CWIDTH-1:0] count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic              bypass;

    assign rd_ptr  = rd_ptr_q;
    assign wr_ptr  = wr_ptr_q;
    assign count_o = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CWIDTH'(DEPTH));
    assign stall_o = (count_q >= CWIDTH'(DEPTH - SLACK));

    assign bypass      = BYPASS_EN && empty && valid_i && !flush_i;
    assign req_o       = !flush_i && (!empty || bypass);
    assign read_i      = gnt_i && !empty && !flush_i;
    // A bypassed word that is granted goes straight through and never occupies storage.
    assign write_i     = valid_i && !flush_i && !(bypass && gnt_i) && (!full || read_i);
    assign overflow_o  = valid_i && full && !read_i && !flush_i;
    assign underflow_o = gnt_i && !req_o && !flush_i;

    always_comb begin
        data_o = '0;
        if (bypass) begin
            data_o = data_i;
        end else if (!empty) begin
            data_o = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain overflow.
            if (read_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (write_i) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({write_i, read_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (write_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_bypass_fifo_path.sv
// Randomized and directed checks of bypass_fifo_path against a queue-based model.
module tb_bypass_fifo_path;

    localparam int unsigned DEPTH_C = 4;
    localparam int unsigned SLACK_C = 1;

    logic       clk, rst_n;
    logic       valid_i, gnt_i, flush_i;
    logic [7:0] data_i;

    logic       stall_o, req_o, write_i, read_i, empty, full, overflow_o, underflow_o;
    logic [7:0] data_o;
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count_o;

    logic       nb_stall, nb_req, nb_write, nb_read, nb_empty, nb_full, nb_ovf, nb_unf;
    logic [7:0] nb_data;
    logic [1:0] nb_rd_ptr, nb_wr_ptr;
    logic [2:0] nb_count;

    int n_tests = 0;
    int n_fail  = 0;

    bypass_fifo_path #(
        .DWIDTH(8), .DEPTH(DEPTH_C), .SLACK(SLACK_C), .BYPASS_EN(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .stall_o(stall_o),
        .req_o(req_o), .gnt_i(gnt_i), .data_o(data_o), .flush_i(flush_i),
        .write_i(write_i), .read_i(read_i), .empty(empty), .full(full),
        .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .count_o(count_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    bypass_fifo_path #(
        .DWIDTH(8), .DEPTH(DEPTH_C), .SLACK(0), .BYPASS_EN(1'b0)
    ) u_nobyp (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .stall_o(nb_stall),
        .req_o(nb_req), .gnt_i(gnt_i), .data_o(nb_data), .flush_i(flush_i),
        .write_i(nb_write), .read_i(nb_read), .empty(nb_empty), .full(nb_full),
        .rd_ptr(nb_rd_ptr), .wr_ptr(nb_wr_ptr), .count_o(nb_count),
        .overflow_o(nb_ovf), .underflow_o(nb_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: queue of stored words, plus pop/push counts since the last flush or reset.
    logic [7:0]  mq[$];
    int unsigned pops, pushes;
    logic        e_read, e_write;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pops   = 0;
        pushes = 0;
    endtask

    // Drive one cycle's inputs and compare every output with the model before the edge.
    task automatic apply(input logic v, input logic [7:0] d, input logic g, input logic f);
        int unsigned sz;
        logic        m_empty, m_full, byp, m_req, m_ovf, m_unf;
        logic [7:0]  m_data;
        @(negedge clk);
        valid_i = v;
        data_i  = d;
        gnt_i   = g;
        flush_i = f;
        #2;
        sz      = mq.size();
        m_empty = (sz == 0);
        m_full  = (sz == DEPTH_C);
        byp     = m_empty && v && !f;
        m_req   = !f && (!m_empty || byp);
        m_data  = byp ? d : (!m_empty ? mq[0] : 8'h00);
        e_read  = g && !m_empty && !f;
        e_write = v && !f && !(byp && g) && (!m_full || e_read);
        m_ovf   = v && m_full && !e_read && !f;
        m_unf   = g && !m_req && !f;
        check("req",   32'(req_o),       32'(m_req));
        check("data",  32'(data_o),      32'(m_data));
        check("read",  32'(read_i),      32'(e_read));
        check("write", 32'(write_i),     32'(e_write));
        check("stall", 32'(stall_o),     32'(sz >= DEPTH_C - SLACK_C));
        check("empty", 32'(empty),       32'(m_empty));
        check("full",  32'(full),        32'(m_full));
        check("count", 32'(count_o),     sz);
        check("rdptr", 32'(rd_ptr),      pops % DEPTH_C);
        check("wrptr", 32'(wr_ptr),      pushes % DEPTH_C);
        check("ovf",   32'(overflow_o),  32'(m_ovf));
        check("unf",   32'(underflow_o), 32'(m_unf));
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        if (flush_i) begin
            model_reset();
        end else begin
            if (e_read) begin
                void'(mq.pop_front());
                pops++;
            end
            if (e_write) begin
                mq.push_back(data_i);
                pushes++;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic g, input logic f);
        apply(v, d, g, f);
        commit();
    endtask

    initial begin
        int unsigned sz;
        logic        v;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        gnt_i   = 1'b0;
        flush_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        // Bypass with grant: same-cycle delivery, nothing stored.
        cyc(1'b1, 8'hA5, 1'b1, 1'b0);
        // Bypass without grant: stored, then drained.
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        // Fill, overflow, then push/pop at full across the pointer wrap.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        apply(1'b1, 8'h99, 1'b0, 1'b0);
        check("ovf_at_full", 32'(overflow_o), 32'd1);
        commit();
        cyc(1'b1, 8'h05, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        // Flush at count 3 with grant, then underflow on empty.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_empty", 32'(underflow_o), 32'd1);
        commit();

        // Without bypass a word appears one cycle after valid_i.
        apply(1'b1, 8'h5A, 1'b1, 1'b0);
        check("nb_req0",   32'(nb_req),   32'd0);
        check("nb_write0", 32'(nb_write), 32'd1);
        commit();
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        check("nb_req1",  32'(nb_req),  32'd1);
        check("nb_data1", 32'(nb_data), 32'h5A);
        commit();
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Stall at count 3 with SLACK 1, then asynchronous reset between edges.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        check("stall_slack", 32'(stall_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_empty", 32'(empty),   32'd1);
        check("rst_full",  32'(full),    32'd0);
        check("rst_req",   32'(req_o),   32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_ptrs",  32'({rd_ptr, wr_ptr}), 32'd0);
        check("rst_data",  32'(data_o),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'hC3, 1'b1, 1'b0);

        for (int n = 0; n < 600; n++) begin
            sz = mq.size();
            if (sz >= DEPTH_C - SLACK_C) v = ($urandom_range(0, 99) < 25);
            else v = ($urandom_range(0, 99) < 60);
            cyc(v, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bypass_fifo_path.md
BYPASS_FIFO_PATH -- requirements
Module: bypass_fifo_path

Interface
REQ-001 Parameter DWIDTH, default 8: data width in bits, >= 1.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of 2, >= 2.
REQ-003 Parameter SLACK, default 0: stall headroom in entries, 0..DEPTH-1.
REQ-004 Parameter BYPASS_EN, default 1: 1 enables the zero-latency empty bypass; 0 forces every word through storage.
REQ-005 Derived PWIDTH = log2(DEPTH); CWIDTH = log2(DEPTH)+1.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 valid_i  input  1  upstream word present on data_i.
REQ-009 data_i  input  DWIDTH  upstream data.
REQ-010 stall_o  output  1  upstream must hold valid_i low while high.
REQ-011 req_o  output  1  downstream word available on data_o.
REQ-012 gnt_i  input  1  downstream consumes data_o this cycle.
REQ-013 data_o  output  DWIDTH  downstream data.
REQ-014 flush_i  input  1  synchronous discard of all stored data.
REQ-015 write_i, read_i  output  1 each  internal push / pop strobes, exported for checking.
REQ-016 empty, full  output  1 each  occupancy flags.
REQ-017 rd_ptr, wr_ptr  output  PWIDTH each  storage pointers.
REQ-018 count_o  output  CWIDTH  stored entries, 0..DEPTH.
REQ-019 overflow_o, underflow_o  output  1 each  single-cycle error pulses.

Function
REQ-020 bypass = BYPASS_EN && empty && valid_i && !flush_i.
REQ-021 req_o = !flush_i && (!empty || bypass); combinational.
REQ-022 data_o = data_i when bypass, else storage[rd_ptr] when !empty, else 0.
REQ-023 read_i = gnt_i && !empty && !flush_i; pops head, rd_ptr increments modulo DEPTH.
REQ-024 write_i = valid_i && !flush_i && !(bypass && gnt_i) && (!full || read_i); stores data_i at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-025 Bypass with gnt_i: word delivered in the same cycle, never stored; zero latency.
REQ-026 Bypass without gnt_i: word stored; data_o presents it from the next cycle; one-cycle latency.
REQ-027 BYPASS_EN=0: minimum latency valid_i to req_o is one cycle.
REQ-028 count_o next = count_o + write_i - read_i; simultaneous push and pop leaves count, empty, full unchanged.
REQ-029 empty = (count_o==0), full = (count_o==DEPTH); both imply rd_ptr==wr_ptr; never both high.
REQ-030 stall_o = (count_o >= DEPTH-SLACK); combinational.
REQ-031 overflow_o pulses when valid_i && full && !read_i && !flush_i; data_i is dropped, state unchanged.
REQ-032 underflow_o pulses when gnt_i && !req_o && !flush_i; no state change.
REQ-033 Data order strictly FIFO; every written word is read exactly once unless flushed.
REQ-034 flush_i has priority over all other inputs: next cycle count_o=0, rd_ptr=wr_ptr=0, empty=1; in the flush cycle req_o=0, write_i=read_i=0, valid_i and gnt_i ignored, no error pulses.
REQ-035 Storage contents need not be cleared by reset or flush.

Reset
REQ-036 rst_n low asynchronously forces count_o=0, rd_ptr=wr_ptr=0, empty=1, full=0.
REQ-037 During and after reset, until new input: req_o=0, data_o=0, stall_o=0, write_i=read_i=0, overflow_o=underflow_o=0.
REQ-038 Reset mid-operation discards all stored words; first post-reset valid_i is treated as empty-FIFO input.

Verification
REQ-039 DEPTH=4, BYPASS_EN=1: empty, valid_i=1, data_i=8'hA5, gnt_i=1 -> same cycle req_o=1, data_o=8'hA5, write_i=0, count_o stays 0.
REQ-040 Empty, data_i=8'h3C with gnt_i=0 -> count_o=1 next cycle, data_o=8'h3C, req_o=1; gnt_i=1 then -> read_i=1, empty=1 next cycle.
REQ-041 Push 8'h01..8'h04 with gnt_i=0 -> full=1, stall_o=1, rd_ptr==wr_ptr=0; fifth valid_i -> overflow_o=1 one cycle, count_o stays 4.
REQ-042 Full, valid_i=1 data_i=8'h05, gnt_i=1 -> pops 8'h01, stores 8'h05, count_o stays 4; subsequent reads yield 8'h02,8'h03,8'h04,8'h05 across pointer wrap.
REQ-043 count_o=3, flush_i=1 with gnt_i=1 -> req_o=0, read_i=0 that cycle; next cycle empty=1, pointers 0; gnt_i on empty -> underflow_o=1.
REQ-044 SLACK=1, DEPTH=4: stall_o=1 at count_o=3; assert rst_n=0 mid-stream -> all outputs reach reset values immediately, before next clk edge.
